// File: rtl/uart_tx_ctrl.sv
// Frame-sequencing FSM for the UART transmitter: schedules start, data, optional parity and stop phases.
// Define UART_TX_STOP2_EN to stretch the stop phase to two bit times.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       Ser_Done,
  output logic       Ser_En,
  output logic [1:0] Mux_Sel,
  output logic       BUSY,
  output logic       Frame_Done,
  output logic       Seq_Err,
  output logic [2:0] Dbg_State
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic             seq_err_q, seq_err_d;
  logic             ser_en_q, busy_q, frame_done_q;
  logic [1:0]       mux_sel_q;
  logic             frame_done_d;
`ifdef UART_TX_STOP2_EN
  logic             stop_q, stop_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    seq_err_d = seq_err_q;
`ifdef UART_TX_STOP2_EN
    stop_d    = stop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Data_Valid) begin
          state_d  = S_START;
          par_en_d = PAR_EN;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          // Counter holds at its last value so it can never wrap.
          state_d = par_en_q ? S_PARITY : S_STOP;
          if (!Ser_Done) seq_err_d = 1'b1;
`ifdef UART_TX_STOP2_EN
          stop_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        state_d = S_STOP;
`ifdef UART_TX_STOP2_EN
        stop_d = 1'b0;
`endif
      end
      S_STOP: begin
`ifdef UART_TX_STOP2_EN
        if (!stop_q) stop_d = 1'b1;
        else         state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_TX_STOP2_EN
  assign frame_done_d = (state_d == S_STOP) && stop_d;
`else
  assign frame_done_d = (state_d == S_STOP);
`endif

  // Outputs are decoded from the next state and registered, so they line up with the state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      par_en_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mux_sel_q    <= 2'b11;
`ifdef UART_TX_STOP2_EN
      stop_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      par_en_q     <= par_en_d;
      seq_err_q    <= seq_err_d;
      ser_en_q     <= (state_d == S_DATA);
      busy_q       <= (state_d != S_IDLE);
      frame_done_q <= frame_done_d;
      case (state_d)
        S_START:  mux_sel_q <= 2'b00;
        S_DATA:   mux_sel_q <= 2'b01;
        S_PARITY: mux_sel_q <= 2'b10;
        default:  mux_sel_q <= 2'b11;
      endcase
`ifdef UART_TX_STOP2_EN
      stop_q       <= stop_d;
`endif
    end
  end

  assign Ser_En     = ser_en_q;
  assign Mux_Sel    = mux_sel_q;
  assign BUSY       = busy_q;
  assign Frame_Done = frame_done_q;
  assign Seq_Err    = seq_err_q;
  assign Dbg_State  = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level reference model builds the expected
// per-cycle output sequence of each accepted frame; honours UART_TX_STOP2_EN like the design.
module tb_uart_tx_ctrl;

  localparam int W = 8;
`ifdef UART_TX_STOP2_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  // Entry layout: {last_data, busy, ser_en, frame_done, mux_sel[1:0]}
  localparam logic [5:0] E_IDLE  = 6'b0_0_0_0_11;
  localparam logic [5:0] E_START = 6'b0_1_0_0_00;
  localparam logic [5:0] E_DATA  = 6'b0_1_1_0_01;
  localparam logic [5:0] E_LAST  = 6'b1_1_1_0_01;
  localparam logic [5:0] E_PAR   = 6'b0_1_0_0_10;
  localparam logic [5:0] E_STOP  = 6'b0_1_0_0_11;
  localparam logic [5:0] E_STOPD = 6'b0_1_0_1_11;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       ser_done = 1'b1;
  logic       ser_en, busy, frame_done, seq_err;
  logic [1:0] mux_sel;
  logic [2:0] dbg_state;
  logic [4:0] obs;

  logic [5:0] exp_q[$];
  logic [5:0] cur = E_IDLE;
  logic       seq_err_exp = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(clk), .RST(rst), .Data_Valid(data_valid), .PAR_EN(par_en), .Ser_Done(ser_done),
    .Ser_En(ser_en), .Mux_Sel(mux_sel), .BUSY(busy), .Frame_Done(frame_done),
    .Seq_Err(seq_err), .Dbg_State(dbg_state)
  );

  assign obs = {busy, ser_en, frame_done, mux_sel};

  // Clock / reset
  always #5 clk = ~clk;

  // Expected outputs of a whole frame, one entry per cycle, ending with the mandatory idle bit.
  task automatic push_frame(input logic par);
    exp_q.push_back(E_START);
    for (int i = 0; i < W; i++) exp_q.push_back((i == W - 1) ? E_LAST : E_DATA);
    if (par) exp_q.push_back(E_PAR);
    for (int i = 0; i < NSTOP; i++) exp_q.push_back((i == NSTOP - 1) ? E_STOPD : E_STOP);
    exp_q.push_back(E_IDLE);
  endtask

  // Driver: apply inputs for one cycle and advance the reference model across the edge.
  task automatic tick(input logic dv, input logic par, input logic sd, input logic r);
    @(negedge clk);
    data_valid = dv;
    par_en     = par;
    ser_done   = sd;
    rst        = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      cur         = E_IDLE;
      seq_err_exp = 1'b0;
    end else begin
      if (cur[5] && !sd) seq_err_exp = 1'b1;
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else if (dv) begin
        push_frame(par);
        cur = exp_q.pop_front();
      end else cur = E_IDLE;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (obs !== E_IDLE[4:0]) begin
      n_fail++; $display("FAIL reset_outputs obs=%b exp=%b", obs, E_IDLE[4:0]);
    end
    n_tests++;
    if (seq_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_seq_err obs=%b exp=0", seq_err);
    end
  endtask

  task automatic run_frame(input string name, input logic par_start, input int toggle_at);
    int busy_n = 0, ser_n = 0, par_n = 0, fd_n = 0;
    logic p;
    tick(1'b1, par_start, 1'b1, 1'b0);
    for (int c = 0; c < W + NSTOP + 4; c++) begin
      n_tests++;
      if (obs !== cur[4:0]) begin
        n_fail++; $display("FAIL %s cyc=%0d obs=%b exp=%b", name, c, obs, cur[4:0]);
      end
      busy_n += int'(busy); ser_n += int'(ser_en); fd_n += int'(frame_done);
      par_n  += int'(mux_sel == 2'b10);
      p = (toggle_at >= 0 && c >= toggle_at) ? ~par_start : par_start;
      tick(1'b0, p, 1'b1, 1'b0);
    end
    n_tests++;
    if (busy_n != W + 1 + NSTOP + int'(par_start)) begin
      n_fail++; $display("FAIL %s_busy_len obs=%0d exp=%0d", name, busy_n, W + 1 + NSTOP + int'(par_start));
    end
    n_tests++;
    if (ser_n != W || par_n != int'(par_start) || fd_n != 1) begin
      n_fail++; $display("FAIL %s_counts ser_en=%0d parity=%0d fdone=%0d exp %0d/%0d/1", name, ser_n, par_n, fd_n, W, int'(par_start));
    end
  endtask

  task automatic test_back_to_back();
    int period = W + 2 + NSTOP + 1;
    int fd_n = 0;
    for (int c = 0; c < 3 * period; c++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      n_tests++;
      if (obs !== cur[4:0]) begin
        n_fail++; $display("FAIL back_to_back cyc=%0d obs=%b exp=%b", c, obs, cur[4:0]);
      end
      fd_n += int'(frame_done);
    end
    n_tests++;
    if (fd_n < 2 || fd_n > 3) begin
      n_fail++; $display("FAIL back_to_back_frames obs=%0d exp=2..3", fd_n);
    end
    for (int c = 0; c < W + 6; c++) tick(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++;
    if (obs !== E_DATA[4:0]) begin
      n_fail++; $display("FAIL reset_mid_pre obs=%b exp=%b", obs, E_DATA[4:0]);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_tests++;
    if (obs !== E_IDLE[4:0] || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_abort obs=%b exp=%b", obs, E_IDLE[4:0]);
    end
    run_frame("after_reset", 1'($urandom_range(0, 1)), -1);
  endtask

  task automatic test_seq_err();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < W + NSTOP + 6; c++) begin
      n_tests++;
      if (seq_err !== seq_err_exp || obs !== cur[4:0]) begin
        n_fail++; $display("FAIL seq_err cyc=%0d obs=%b/%b exp=%b/%b", c, seq_err, obs, seq_err_exp, cur[4:0]);
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_tests++;
    if (seq_err !== 1'b1) begin
      n_fail++; $display("FAIL seq_err_sticky obs=%b exp=1", seq_err);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    n_tests++;
    if (seq_err !== 1'b0) begin
      n_fail++; $display("FAIL seq_err_clear obs=%b exp=0", seq_err);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      tick(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 59) == 0));
      n_tests++;
      if (obs !== cur[4:0] || seq_err !== seq_err_exp) begin
        n_fail++; $display("FAIL random cyc=%0d obs=%b/%b exp=%b/%b", c, obs, seq_err, cur[4:0], seq_err_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    run_frame("parity_frame", 1'b1, -1);
    run_frame("no_parity_frame", 1'b0, -1);
    run_frame("par_toggle", 1'b1, 3);
    test_back_to_back();
    test_reset_mid();
    test_seq_err();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
